// File: rtl/calc_pkg.sv
// Shared calculator definitions: opcodes, key codes and entry phases.
package calc_pkg;

    typedef enum logic [1:0] {
        OP_SOMA = 2'b00,
        OP_SUB  = 2'b01,
        OP_MUL  = 2'b10,
        OP_DIV  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ENTER_A = 2'b00,
        ENTER_B = 2'b01,
        DONE    = 2'b10
    } phase_t;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_DIV = 4'hD;
    localparam logic [3:0] KEY_BS  = 4'hE;
    localparam logic [3:0] KEY_EQ  = 4'hF;

    // Operator keys A..D map onto opcodes 0..3 in order.
    function automatic op_t key_to_op(input logic [3:0] code);
        logic [3:0] diff;
        diff = code - KEY_ADD;
        return op_t'(diff[1:0]);
    endfunction

endpackage

// File: rtl/operand_entry_dec_accum.sv
// Decimal digit accumulator: holds the operand being typed and its digit
// count, appends digits MSD first with overflow/length checks.
// Optional feature macro: BACKSPACE_EN (enables divide-by-10 digit removal).
module dec_accum #(
    parameter int WIDTH      = 8,
    parameter int MAX_DIGITS = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear,
    input  logic                              append,
    input  logic                              backspace,
    input  logic [3:0]                        digit,
    output logic [WIDTH-1:0]                  value,
    output logic [$clog2(MAX_DIGITS+1)-1:0]   ndig,
    output logic                              reject
);
    localparam int NW = $clog2(MAX_DIGITS + 1);
    localparam logic [WIDTH+3:0] MAX_VAL = {4'b0000, {WIDTH{1'b1}}};

    logic [WIDTH-1:0] value_reg;
    logic [NW-1:0]    ndig_reg;
    logic [WIDTH-1:0] base_value;
    logic [NW-1:0]    base_ndig;
    logic [WIDTH+3:0] tmp;

    // Clear-and-append starts a fresh operand with the new digit in one step.
    always_comb begin
        base_value = clear ? '0 : value_reg;
        base_ndig  = clear ? '0 : ndig_reg;
        tmp        = ({4'b0000, base_value} * (WIDTH+4)'(10)) + {{WIDTH{1'b0}}, digit};
        reject     = append && ((base_ndig == NW'(MAX_DIGITS)) || (tmp > MAX_VAL));
    end

`ifndef BACKSPACE_EN
    logic unused_backspace;
    assign unused_backspace = backspace;
`endif

    // Operand register: rejected digits leave the value untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_reg <= '0;
            ndig_reg  <= '0;
        end else if (append && !reject) begin
            value_reg <= tmp[WIDTH-1:0];
            ndig_reg  <= base_ndig + NW'(1);
        end else if (clear) begin
            value_reg <= '0;
            ndig_reg  <= '0;
`ifdef BACKSPACE_EN
        end else if (backspace && (ndig_reg != '0)) begin
            value_reg <= value_reg / WIDTH'(10);
            ndig_reg  <= ndig_reg - NW'(1);
`endif
        end
    end

    assign value = value_reg;
    assign ndig  = ndig_reg;

endmodule

// File: rtl/operand_entry.sv
// Keypad front end: collects operands A/B and an opcode from key presses and
// pulses go one cycle after an accepted equals key.
// Optional feature macro: BACKSPACE_EN (key E removes the last digit).
module operand_entry
    import calc_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MAX_DIGITS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       key_code,
    input  logic             key_valid,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [1:0]       op,
    output logic             go,
    output logic [WIDTH-1:0] entry,
    output logic [1:0]       phase,
    output logic             err
);
    localparam int NW = $clog2(MAX_DIGITS + 1);

    phase_t           phase_reg, phase_next;
    op_t              op_reg, op_next;
    logic [WIDTH-1:0] a_reg, a_next, b_reg, b_next;
    logic             go_reg, go_next, err_reg, err_next;
    logic             acc_clear, acc_append, acc_backspace, acc_reject;
    logic             accept, rejected;
    logic [WIDTH-1:0] acc_value;
    logic [NW-1:0]    acc_ndig;

    dec_accum #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) u_accum (
        .clk       (clk),
        .rst       (rst),
        .clear     (acc_clear),
        .append    (acc_append),
        .backspace (acc_backspace),
        .digit     (key_code),
        .value     (acc_value),
        .ndig      (acc_ndig),
        .reject    (acc_reject)
    );

    // State register; reset wins over any key in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_reg <= ENTER_A;
            op_reg    <= OP_SOMA;
            a_reg     <= '0;
            b_reg     <= '0;
            go_reg    <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            phase_reg <= phase_next;
            op_reg    <= op_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            go_reg    <= go_next;
            err_reg   <= err_next;
        end
    end

    // Key decode and next-state logic; ignored keys neither accept nor reject.
    always_comb begin
        phase_next    = phase_reg;
        op_next       = op_reg;
        a_next        = a_reg;
        b_next        = b_reg;
        go_next       = 1'b0;
        acc_clear     = 1'b0;
        acc_append    = 1'b0;
        acc_backspace = 1'b0;
        accept        = 1'b0;
        rejected      = 1'b0;
        if (key_valid && !rst) begin
            if (key_code <= 4'd9) begin
                acc_append = 1'b1;
                if (phase_reg == DONE) begin
                    acc_clear  = 1'b1;
                    a_next     = '0;
                    b_next     = '0;
                    phase_next = ENTER_A;
                end else if (phase_reg != ENTER_B) begin
                    phase_next = ENTER_A;
                end
                if (acc_reject) rejected = 1'b1;
                else            accept   = 1'b1;
            end else if (key_code <= KEY_DIV) begin
                case (phase_reg)
                    ENTER_B: begin
                        if (acc_ndig == '0) begin
                            op_next = key_to_op(key_code);
                            accept  = 1'b1;
                        end else begin
                            rejected = 1'b1;
                        end
                    end
                    DONE: begin
                        op_next    = key_to_op(key_code);
                        b_next     = '0;
                        acc_clear  = 1'b1;
                        phase_next = ENTER_B;
                        accept     = 1'b1;
                    end
                    default: begin
                        a_next     = acc_value;
                        op_next    = key_to_op(key_code);
                        acc_clear  = 1'b1;
                        phase_next = ENTER_B;
                        accept     = 1'b1;
                    end
                endcase
            end else if (key_code == KEY_BS) begin
`ifdef BACKSPACE_EN
                if ((phase_reg != DONE) && (acc_ndig != '0)) begin
                    acc_backspace = 1'b1;
                    accept        = 1'b1;
                end
`else
                rejected = 1'b1;
`endif
            end else begin
                case (phase_reg)
                    ENTER_B: begin
                        if (acc_ndig == '0) begin
                            rejected = 1'b1;
                        end else if ((op_reg == OP_DIV) && (acc_value == '0)) begin
                            rejected = 1'b1;
                        end else begin
                            b_next     = acc_value;
                            go_next    = 1'b1;
                            phase_next = DONE;
                            accept     = 1'b1;
                        end
                    end
                    DONE: begin
                        go_next = 1'b1;
                        accept  = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
        err_next = rejected ? 1'b1 : (accept ? 1'b0 : err_reg);
    end

    assign A     = a_reg;
    assign B     = b_reg;
    assign op    = op_reg;
    assign go    = go_reg;
    assign entry = acc_value;
    assign phase = phase_reg;
    assign err   = err_reg;

endmodule

// File: tb/tb_operand_entry.sv
// Directed self-checking bench for operand_entry (WIDTH=8, MAX_DIGITS=3).
module tb_operand_entry;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_code = 4'h0;
    logic       key_valid = 1'b0;
    logic [7:0] A, B, entry;
    logic [1:0] op, phase;
    logic       go, err;

    int n_checks = 0;
    int n_fail   = 0;

    operand_entry #(.WIDTH(8), .MAX_DIGITS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_code  (key_code),
        .key_valid (key_valid),
        .A         (A),
        .B         (B),
        .op        (op),
        .go        (go),
        .entry     (entry),
        .phase     (phase),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One key press: strobe for a single cycle, outputs sampled at the next negedge.
    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_code  = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        $display("key %h -> A=%0d B=%0d op=%0d go=%0b entry=%0d phase=%0d err=%0b",
                 k, A, B, op, go, entry, phase, err);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        key_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_A"}, 32'(A), 0);
        check({tag, "_B"}, 32'(B), 0);
        check({tag, "_op"}, 32'(op), 0);
        check({tag, "_go"}, 32'(go), 0);
        check({tag, "_entry"}, 32'(entry), 0);
        check({tag, "_phase"}, 32'(phase), 0);
        check({tag, "_err"}, 32'(err), 0);
    endtask

    initial begin
        do_reset();
        check_reset_state("reset");

        // Test 1: 12 + 34
        press(4'h1); check("t1_entry1", 32'(entry), 1);
        press(4'h2); check("t1_entry12", 32'(entry), 12);
        press(4'hA);
        check("t1_phaseB", 32'(phase), 1);
        check("t1_A_latched", 32'(A), 12);
        check("t1_entry_cleared", 32'(entry), 0);
        press(4'h3); press(4'h4); check("t1_entry34", 32'(entry), 34);
        press(4'hF);
        check("t1_go", 32'(go), 1);
        check("t1_A", 32'(A), 12);
        check("t1_B", 32'(B), 34);
        check("t1_op", 32'(op), 0);
        check("t1_phase_done", 32'(phase), 2);
        idle(); check("t1_go_one_cycle", 32'(go), 0);

        // Test 4: chaining from DONE, then repeated equals
        press(4'hC);
        check("t4_phaseB", 32'(phase), 1);
        check("t4_op_mul", 32'(op), 2);
        check("t4_A_kept", 32'(A), 12);
        check("t4_B_cleared", 32'(B), 0);
        press(4'h2); press(4'hF);
        check("t4_go", 32'(go), 1);
        check("t4_A", 32'(A), 12);
        check("t4_B", 32'(B), 2);
        check("t4_op", 32'(op), 2);
        idle(); check("t4_go_low", 32'(go), 0);
        press(4'hF);
        check("t4_go_repeat", 32'(go), 1);
        check("t4_B_repeat", 32'(B), 2);
        check("t4_err_repeat", 32'(err), 0);

        // Test 3: divide by zero rejected, then 9/3
        do_reset();
        press(4'h9); press(4'hD); press(4'h0); press(4'hF);
        check("t3_div0_err", 32'(err), 1);
        check("t3_div0_go", 32'(go), 0);
        check("t3_div0_phase", 32'(phase), 1);
        press(4'h3);
        check("t3_err_cleared", 32'(err), 0);
        check("t3_entry3", 32'(entry), 3);
        press(4'hF);
        check("t3_go", 32'(go), 1);
        check("t3_A", 32'(A), 9);
        check("t3_B", 32'(B), 3);
        check("t3_op", 32'(op), 3);
        // Digit in DONE starts a new calculation
        press(4'h7);
        check("done_digit_phase", 32'(phase), 0);
        check("done_digit_A", 32'(A), 0);
        check("done_digit_B", 32'(B), 0);
        check("done_digit_entry", 32'(entry), 7);

        // Test 2: overflow and digit-count limits
        do_reset();
        press(4'h2); press(4'h5); check("t2_entry25", 32'(entry), 25);
        press(4'h6);
        check("t2_ovf_err", 32'(err), 1);
        check("t2_ovf_entry", 32'(entry), 25);
        press(4'h7); check("t2_ovf2_entry", 32'(entry), 25);
        press(4'hF);
        check("t2_eq_in_A_err_kept", 32'(err), 1);
        check("t2_eq_in_A_phase", 32'(phase), 0);
        check("t2_eq_in_A_go", 32'(go), 0);
        press(4'h1);
        check("t2_entry251", 32'(entry), 251);
        check("t2_err_cleared", 32'(err), 0);
        press(4'h0);
        check("t2_maxdig_err", 32'(err), 1);
        check("t2_maxdig_entry", 32'(entry), 251);
        press(4'hA); check("t2_A251", 32'(A), 251);
        press(4'h5); press(4'hB);
        check("t2_op_with_digits_err", 32'(err), 1);
        check("t2_op_unchanged", 32'(op), 0);

        // Test 5: reset with a simultaneous key press
        do_reset();
        press(4'h4); press(4'h5); check("t5_entry45", 32'(entry), 45);
        @(negedge clk);
        key_code = 4'h6; key_valid = 1'b1; rst = 1'b1;
        @(negedge clk);
        key_valid = 1'b0; rst = 1'b0;
        check_reset_state("t5_mid_reset");

        // Test 6: backspace
        do_reset();
        press(4'h1); press(4'h2); press(4'h3);
        press(4'hE);
`ifdef BACKSPACE_EN
        check("t6_bs_entry12", 32'(entry), 12);
        check("t6_bs_err", 32'(err), 0);
        press(4'h4); check("t6_ndig2_append", 32'(entry), 124);
        press(4'hE); press(4'hE); press(4'hE);
        check("t6_bs_empty", 32'(entry), 0);
        press(4'hE);
        check("t6_bs_ignored_entry", 32'(entry), 0);
        check("t6_bs_ignored_err", 32'(err), 0);
`else
        check("t6_bs_err", 32'(err), 1);
        check("t6_bs_entry123", 32'(entry), 123);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
